// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lsu_pkg                                                           |
// | Brief  : Shared types for the load/store unit: access size encoding, FSM   |
// |          state encoding and the request fault check.                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LOAD  = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    ERR   = 3'd5
  } state_e;

  // True when the access cannot be performed: bad size code or an address
  // that is not naturally aligned for the access size.
  function automatic logic req_faults(input size_e size, input logic [1:0] lo);
    logic f;
    case (size)
      HALF:    f = lo[0];
      WORD:    f = (lo != 2'b00);
      ILLEGAL: f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lsu_align                                                         |
// | Brief  : Combinational lane logic. Builds the read-modify-write word for   |
// |          sub-word stores and extracts/extends the addressed lane of a      |
// |          load word.                                                        |
// | Ports  : size_i      access size                                          |
// |          unsigned_i  zero-extend loads when high                          |
// |          lane_i      byte offset within the word                          |
// |          wdata_i     right-aligned store data                             |
// |          rdata_i     memory word                                          |
// |          merged_o    rdata_i with the store lane replaced                 |
// |          extracted_o extended load result                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] extracted_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (lane_i)
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      2'd3:    w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      BYTE:    extracted_o = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
      HALF:    extracted_o = {{16{w_half[15] & ~unsigned_i}}, w_half};
      default: extracted_o = rdata_i;
    endcase

    merged_o = rdata_i;
    case (size_i)
      BYTE: begin
        case (lane_i)
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          2'd3:    merged_o[31:24] = wdata_i[7:0];
          default: merged_o[7:0]   = wdata_i[7:0];
        endcase
      end
      HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lsu_ctrl                                                          |
// | Brief  : Load/store controller in front of a word-wide synchronous data    |
// |          memory. Word stores write directly; loads read then extract;      |
// |          sub-word stores read, merge the lane and write back.              |
// | Config : LSU_MISALIGN_CHECK_EN - when defined, misaligned and size-11       |
// |          requests complete through ERR with misalign set and no write.     |
// |          When undefined, size 11 acts as word and the low address bits     |
// |          are forced to the access alignment.                               |
// | Ports  : req_*   request channel (valid/ready handshake)                  |
// |          resp_*  one-cycle completion pulse, load data, misalign flag     |
// |          mem_*   data memory, word index addressing, 1-cycle read         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int N = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        mem_we,
  output logic [N:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e       state_q, state_d;
  logic         we_q;
  size_e        size_q;
  logic         unsigned_q;
  logic [N+2:0] addr_q;
  logic [31:0]  wdata_q;
  logic         resp_valid_q;
  logic         mem_we_q;
  logic [N:0]   mem_addr_q;

  size_e        w_size_eff;
  logic [N+2:0] w_addr_eff;
  logic [N+2:0] w_addr_nx;
  logic         w_err;
  logic         w_accept;
  logic [31:0]  w_merged;
  logic [31:0]  w_extracted;

  // Address bits above the memory window are ignored (addresses wrap).
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^req_addr[31:N+3];

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;
  assign w_size_eff = size_e'(req_size);
  assign w_addr_eff = req_addr[N+2:0];
  assign w_err      = req_faults(size_e'(req_size), req_addr[1:0]);
  assign misalign   = misalign_q;
`else
  // No error path: coerce the request into a legal, aligned access.
  always_comb begin
    w_size_eff = size_e'(req_size);
    w_addr_eff = req_addr[N+2:0];
    case (size_e'(req_size))
      HALF: w_addr_eff[0] = 1'b0;
      WORD, ILLEGAL: begin
        w_size_eff      = WORD;
        w_addr_eff[1:0] = 2'b00;
      end
      default: ;
    endcase
  end
  assign w_err    = 1'b0;
  assign misalign = 1'b0;
`endif

  assign w_accept  = req_valid && (state_q == IDLE);
  // Address for the cycle being entered: fresh request on accept, else latched.
  assign w_addr_nx = w_accept ? w_addr_eff : addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (w_err)                            state_d = ERR;
          else if (req_we && w_size_eff == WORD) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD:      state_d = we_q ? MERGE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= BYTE;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        we_q       <= req_we;
        size_q     <= w_size_eff;
        unsigned_q <= req_unsigned;
        addr_q     <= w_addr_eff;
        wdata_q    <= req_wdata;
      end
      resp_valid_q <= (state_d == LOAD) || (state_d == MERGE) ||
                      (state_d == WR)   || (state_d == ERR);
      mem_we_q     <= (state_d == MERGE) || (state_d == WR);
      mem_addr_q   <= ((state_d == RD) || (state_d == MERGE) || (state_d == WR)) ?
                      w_addr_nx[N+2:2] : '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q   <= (state_d == ERR);
`endif
    end
  end

  lsu_align u_align (
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .lane_i      (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .merged_o    (w_merged),
    .extracted_o (w_extracted)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;

  // Data paths depend on mem_rdata, which only arrives in LOAD/MERGE.
  always_comb begin
    case (state_q)
      WR:      mem_wdata = wdata_q;
      MERGE:   mem_wdata = w_merged;
      default: mem_wdata = '0;
    endcase
  end
  assign resp_rdata = (state_q == LOAD) ? w_extracted : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_lsu_ctrl                                                       |
// | Brief  : Self-checking bench for lsu_ctrl. A request-level model predicts  |
// |          every output cycle by cycle; a compare process checks them, and   |
// |          literal expectations pin the model on key transactions.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;

  localparam int N     = 5;
  localparam int WORDS = 1 << (N + 1);
  localparam int TABSZ = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_load = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        mem_we;
  logic [N:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign     (misalign),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {8'hC0, i, 8'h5A, i};
  endfunction

  // Data memory seen by the DUT: registered read, old data on same-cycle write.
  logic [31:0] dmem [WORDS];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < WORDS; i++) dmem[i] <= init_word(8'(i));
      mem_rdata <= '0;
    end else begin
      mem_rdata <= dmem[mem_addr];
      if (mem_we) dmem[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic        mis;
    logic        we;
    logic [N:0]  ma;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  exp_t        ex_tab [TABSZ];
  logic [31:0] mm [WORDS];
  logic        chk_en = 1'b0;
  exp_t        cmp_e;

  always @(negedge clk) begin
    if (chk_en && cyc < TABSZ) begin
      cmp_e = ex_tab[cyc];
      chk("req_ready",  32'(req_ready),  32'(cmp_e.rdy));
      chk("resp_valid", 32'(resp_valid), 32'(cmp_e.rv));
      chk("misalign",   32'(misalign),   32'(cmp_e.mis));
      chk("mem_we",     32'(mem_we),     32'(cmp_e.we));
      chk("mem_addr",   32'(mem_addr),   32'(cmp_e.ma));
      chk("mem_wdata",  mem_wdata,       cmp_e.wd);
      chk("resp_rdata", resp_rdata,      cmp_e.rd);
    end
  end

  // Request-level prediction of the outputs for a request accepted at the
  // end of cycle t. Memory effects are applied to mm unless aborted.
  task automatic predict(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input bit abort,
                         input int t, output int lat);
    exp_t        e1, e2;
    logic [1:0]  s;
    logic [31:0] aa, old, nw, v, msk;
    logic [N:0]  idx;
    logic [4:0]  sh;
    bit          err;
    s = sz; aa = a; err = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    err = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
`else
    if (s == 2'd3) s = 2'd2;
    if (s == 2'd1) aa = a & ~32'h1;
    if (s == 2'd2) aa = a & ~32'h3;
`endif
    idx = aa[N+2:2];
    sh  = {aa[1:0], 3'b000};
    e1 = idle_e(); e1.rdy = 1'b0;
    e2 = e1;
    if (err) begin
      lat = 1; e1.rv = 1'b1; e1.mis = 1'b1;
    end else if (we && s == 2'd2) begin
      lat = 1; e1.rv = 1'b1; e1.we = 1'b1; e1.ma = idx; e1.wd = d;
      if (!abort) mm[idx] = d;
    end else begin
      lat = 2; e1.ma = idx; e2.rv = 1'b1;
      old = mm[idx];
      msk = (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (we) begin
        nw = (old & ~(msk << sh)) | ((d & msk) << sh);
        e2.we = 1'b1; e2.ma = idx; e2.wd = nw;
        if (!abort) mm[idx] = nw;
      end else begin
        v = (old >> sh) & msk;
        if (!uns && s == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && s == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        e2.rd = v;
      end
    end
    ex_tab[t+1] = e1;
    if (lat == 2 && !abort) ex_tab[t+2] = e2;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that starts the first idle cycle after the request.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input bit abort);
    int t, lat;
    t = cyc;
    predict(we, sz, uns, a, d, abort, t, lat);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    if (lat == 2) begin
      // DUT is busy: a different request presented now must be ignored.
      req_we = ~we; req_size = 2'b10; req_addr = a ^ 32'h14; req_wdata = ~d;
    end else begin
      req_valid = 1'b0;
    end
    if (abort) rst = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    if (lat == 2 && !abort) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_neg(input int k);
    wait (cyc == k);
    @(negedge clk);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < TABSZ; i++) ex_tab[i] = idle_e();
    for (int i = 0; i < WORDS; i++) mm[i] = init_word(8'(i));

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset req_ready",  32'(req_ready),  32'h1);
    chk("reset resp_valid", 32'(resp_valid), 32'h0);
    chk("reset mem_addr",   32'(mem_addr),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_load = 1'b0;

    t0 = cyc;
    fork
      issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0);
      begin
        wait_neg(t0 + 1);
        chk("sw8 mem_we",     32'(mem_we),     32'h1);
        chk("sw8 mem_addr",   32'(mem_addr),   32'h2);
        chk("sw8 resp_valid", 32'(resp_valid), 32'h1);
      end
    join
    t0 = cyc;
    fork
      issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lw8 rdata", resp_rdata, 32'hDEADBEEF); end
    join

    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 1'b0);
    t0 = cyc;
    fork
      issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA, 1'b0);
      begin
        wait_neg(t0 + 2);
        chk("sb9 mem_wdata", mem_wdata,      32'h1122AA44);
        chk("sb9 mem_we",    32'(mem_we),    32'h1);
      end
    join
    t0 = cyc;
    fork
      issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lb9 rdata", resp_rdata, 32'hFFFFFFAA); end
    join
    t0 = cyc;
    fork
      issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lbu9 rdata", resp_rdata, 32'h000000AA); end
    join
    t0 = cyc;
    fork
      issue(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lhA rdata", resp_rdata, 32'h00001122); end
    join

    t0 = cyc;
    fork
      issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
      begin
        wait_neg(t0 + 1);
        chk("lw6 misalign",   32'(misalign),   32'h1);
        chk("lw6 resp_valid", 32'(resp_valid), 32'h1);
      end
`else
      begin wait_neg(t0 + 2); chk("lw6 rdata", resp_rdata, 32'hC0015A01); end
`endif
    join

    // Reset during RD of a half store: nothing written, ready afterwards.
    t0 = cyc;
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF, 1'b1);
    wait_neg(t0 + 2);
    chk("abort req_ready", 32'(req_ready), 32'h1);
    chk("abort mem_we",    32'(mem_we),    32'h0);
    @(posedge clk); #1;
    t0 = cyc;
    fork
      issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lh2 after abort", resp_rdata, 32'hFFFFC000); end
    join

    t0 = cyc;
    fork
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b0);
      begin wait_neg(t0 + 1); chk("sw100 mem_addr wrap", 32'(mem_addr), 32'h0); end
    join
    t0 = cyc;
    fork
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lw0 rdata", resp_rdata, 32'h12345678); end
    join

    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001, 1'b0);
    t0 = cyc;
    fork
      issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0);
      begin wait_neg(t0 + 2); chk("lh16 rdata", resp_rdata, 32'hFFFF8001); end
    join
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000007F, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h7, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) chk($sformatf("mem word %0d", i), dmem[i], mm[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
